// File: rtl/signed_seq_mult.sv
// Sequential 32x32 signed radix-2 Booth multiplier, start/valid handshake.
// VARIABLE_LATENCY=1 stops once the remaining multiplier bits are all equal.
module signed_seq_mult #(
  parameter int VARIABLE_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mlier,
  input  logic [31:0] mcand,
  output logic [63:0] prodt,
  input  logic        start,
  output logic        valid
);

  localparam bit VarLat = (VARIABLE_LATENCY != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_LOW
  } state_t;

  state_t      state, state_n;
  logic [63:0] acc, acc_n;
  logic [63:0] mc, mc_n;
  logic [32:0] mq, mq_n;
  logic [5:0]  cnt, cnt_n;
  logic [63:0] prodt_n;
  logic        valid_n;

  logic [63:0] acc_step;
  logic [32:0] mq_sh;
  logic        mq_uni;
  logic        sh_uni;
  logic        last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mc    <= '0;
      mq    <= '0;
      cnt   <= '0;
      prodt <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mc    <= mc_n;
      mq    <= mq_n;
      cnt   <= cnt_n;
      prodt <= prodt_n;
      valid <= valid_n;
    end
  end

  always_comb begin
    unique case (mq[1:0])
      2'b01:   acc_step = acc + mc;
      2'b10:   acc_step = acc - mc;
      default: acc_step = acc;
    endcase
  end

  assign mq_sh  = {mq[32], mq[32:1]};
  assign mq_uni = (&mq) | (~|mq);
  assign sh_uni = (&mq_sh) | (~|mq_sh);
  // Fixed mode ends on the 32nd step; variable mode once the shifted mq is flat.
  assign last   = VarLat ? sh_uni : (cnt == 6'd31);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mc_n    = mc;
    mq_n    = mq;
    cnt_n   = cnt;
    prodt_n = prodt;
    valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          mc_n    = {{32{mcand[31]}}, mcand};
          mq_n    = {mlier, 1'b0};
          acc_n   = '0;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (VarLat && mq_uni) begin
          prodt_n = acc;
          valid_n = 1'b1;
          state_n = WAIT_LOW;
        end else begin
          acc_n = acc_step;
          mc_n  = mc << 1;
          mq_n  = mq_sh;
          cnt_n = cnt + 6'd1;
          if (last) begin
            prodt_n = acc_step;
            valid_n = 1'b1;
            state_n = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_signed_seq_mult.sv
// Bench for signed_seq_mult: fixed and variable latency instances side by side,
// checked against plain signed arithmetic and a bit-width latency model.
module tb_signed_seq_mult;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mlier;
  logic [31:0] mcand;
  logic        start;
  logic [63:0] prodt_f, prodt_v;
  logic        valid_f, valid_v;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  signed_seq_mult #(.VARIABLE_LATENCY(0)) u_fix (
    .clock(clock), .reset(reset), .mlier(mlier), .mcand(mcand),
    .prodt(prodt_f), .start(start), .valid(valid_f)
  );

  signed_seq_mult #(.VARIABLE_LATENCY(1)) u_var (
    .clock(clock), .reset(reset), .mlier(mlier), .mcand(mcand),
    .prodt(prodt_v), .start(start), .valid(valid_v)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Variable-mode latency: 1 + bits needed to hold mlier as a signed number.
  function automatic int ref_lat_var(input logic [31:0] a);
    longint sa;
    sa = longint'($signed(a));
    if (sa == 0) return 2;
    for (int n = 1; n <= 32; n++) begin
      if (sa >= -(64'sd1 <<< (n - 1)) && sa < (64'sd1 <<< (n - 1)))
        return n + 1;
    end
    return 33;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int edges;
    int lat_f, lat_v, cnt_f, cnt_v;
    logic [63:0] res_f, res_v, exp;
    exp = ref_prod(a, b);
    @(negedge clock);
    mlier = a;
    mcand = b;
    start = 1'b1;
    @(posedge clock);
    edges = 1;
    lat_f = 0; lat_v = 0; cnt_f = 0; cnt_v = 0;
    res_f = '0; res_v = '0;
    @(negedge clock);
    mlier = $urandom;
    mcand = $urandom;
    repeat (45) begin
      @(posedge clock);
      edges++;
      #1;
      if (valid_f) begin
        cnt_f++;
        if (lat_f == 0) begin lat_f = edges; res_f = prodt_f; end
      end
      if (valid_v) begin
        cnt_v++;
        if (lat_v == 0) begin lat_v = edges; res_v = prodt_v; end
      end
    end
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk({tag, ".fix.prod"}, res_f, exp);
    chk({tag, ".var.prod"}, res_v, exp);
    chk({tag, ".fix.lat"}, 64'(lat_f), 64'd33);
    chk({tag, ".var.lat"}, 64'(lat_v), 64'(ref_lat_var(a)));
    chk({tag, ".fix.pulses"}, 64'(cnt_f), 64'd1);
    chk({tag, ".var.pulses"}, 64'(cnt_v), 64'd1);
    chk({tag, ".fix.hold"}, prodt_f, exp);
    chk({tag, ".var.hold"}, prodt_v, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    mlier = '0;
    mcand = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst.fix.prodt", prodt_f, 64'd0);
    chk("rst.var.prodt", prodt_v, 64'd0);
    chk("rst.fix.valid", {63'd0, valid_f}, 64'd0);
    chk("rst.var.valid", {63'd0, valid_v}, 64'd0);

    run_op(32'h7fffffff, 32'h7fffffff, "maxmax");
    chk("maxmax.const", prodt_f, 64'h3FFFFFFF00000001);
    run_op(32'h7fffffff, 32'h80000000, "maxmin");
    chk("maxmin.const", prodt_v, 64'hC000000080000000);
    run_op(32'hffffffff, 32'h7fffffff, "m1max");
    chk("m1max.const", prodt_f, 64'hFFFFFFFF80000001);
    run_op(32'h80000000, 32'h80000000, "minmin");
    chk("minmin.const", prodt_f, 64'h4000000000000000);
    run_op(32'hffffffff, 32'hffffffff, "m1m1");
    chk("m1m1.const", prodt_v, 64'h0000000000000001);
    run_op(32'h00000000, 32'h80000000, "zero_l");
    chk("zero_l.const", prodt_v, 64'd0);
    run_op(32'h80000000, 32'h00000000, "zero_c");
    chk("zero_c.const", prodt_f, 64'd0);
    run_op(32'h00000001, 32'h12345678, "one");
    chk("one.const", prodt_v, 64'h0000000012345678);

    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, $sformatf("rnd%0d", i));
    end

    // Reset mid-operation aborts and clears the product.
    @(negedge clock);
    mlier = 32'h7fffffff;
    mcand = 32'h00000003;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (valid_f || valid_v) seen++;
    end
    chk("abort.valid", 64'(seen), 64'd0);
    chk("abort.fix.prodt", prodt_f, 64'd0);
    chk("abort.var.prodt", prodt_v, 64'd0);

    run_op(32'hfffffffd, 32'h00000007, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
